// File: rtl/gb_timer_pkg.sv
// Shared constants for the gb_timer peripheral: register offsets, clock-select
// bit indices, overflow FSM encoding and the overflow delay length.
package gb_timer_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned TAC_W      = 3;
  localparam int unsigned WAIT_CNT_W = 2;

  localparam logic [1:0] OFS_DIV  = 2'd0;
  localparam logic [1:0] OFS_TIMA = 2'd1;
  localparam logic [1:0] OFS_TMA  = 2'd2;
  localparam logic [1:0] OFS_TAC  = 2'd3;

  // div_cnt bit watched for TAC[1:0] = 00 / 01 / 10 / 11
  localparam int unsigned SEL_BIT_00 = 9;
  localparam int unsigned SEL_BIT_01 = 3;
  localparam int unsigned SEL_BIT_10 = 5;
  localparam int unsigned SEL_BIT_11 = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_RELOAD = 2'd2;

  localparam int unsigned WAIT_LEN = 4;

endpackage

// File: rtl/gb_timer_if.sv
// CPU-side bus of the timer: address, write data, strobes, read data and hit.
interface gb_timer_if;
  import gb_timer_pkg::*;

  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd;
  logic              wr;
  logic              hit;

  modport master (output a, din, rd, wr, input dout, hit);
  modport slave  (input a, din, rd, wr, output dout, hit);
endinterface

// File: rtl/gb_timer_prescaler.sv
// Free-running 16-bit divider with clear-on-write, clock-select mux and
// falling-edge detector producing the TIMA increment pulse.
module gb_timer_prescaler
  import gb_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              div_clr,
  input  logic [TAC_W-1:0]  tac,
  output logic [DATA_W-1:0] div,
  output logic              tick
);

  logic [DIV_W-1:0] div_cnt;
  logic             sel_bit;
  logic             src;
  logic             src_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (div_clr) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    sel_bit = 1'b0;
    case (tac[1:0])
      2'b00:   sel_bit = div_cnt[SEL_BIT_00];
      2'b01:   sel_bit = div_cnt[SEL_BIT_01];
      2'b10:   sel_bit = div_cnt[SEL_BIT_10];
      default: sel_bit = div_cnt[SEL_BIT_11];
    endcase
  end

  assign src = tac[2] & sel_bit;

  // Edge is taken on the gated source, so DIV/TAC writes that drop it also tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= 1'b0;
    end else begin
      src_q <= src;
    end
  end

  assign tick = src_q & ~src;
  assign div  = div_cnt[DIV_W-1:DIV_W-DATA_W];

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer peripheral with overflow interrupt.
// Build option: GB_TIMER_OVF_DELAY_EN enables the 4-clk delayed reload.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF04
) (
  input  logic       clk,
  input  logic       rst,
  gb_timer_if.slave  bus,
  output logic       irq
);

  logic [ADDR_W-1:0] ofs_full;
  logic [1:0]        ofs;
  logic              in_range;
  logic              wr_div, wr_tima, wr_tma, wr_tac;

  logic [DATA_W-1:0] div;
  logic              tick;

  logic [DATA_W-1:0] tima, tima_n;
  logic [DATA_W-1:0] tma;
  logic [TAC_W-1:0]  tac;
  logic              irq_n;

  // Address decode; offsets beyond +3 leave a nonzero upper part
  assign ofs_full = bus.a - BASE_ADDR;
  assign ofs      = ofs_full[1:0];
  assign in_range = (ofs_full[ADDR_W-1:2] == '0);
  assign bus.hit  = in_range & bus.rd;

  assign wr_div  = bus.wr & in_range & (ofs == OFS_DIV);
  assign wr_tima = bus.wr & in_range & (ofs == OFS_TIMA);
  assign wr_tma  = bus.wr & in_range & (ofs == OFS_TMA);
  assign wr_tac  = bus.wr & in_range & (ofs == OFS_TAC);

  gb_timer_prescaler u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .div_clr (wr_div),
    .tac     (tac),
    .div     (div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tma <= '0;
      tac <= '0;
    end else begin
      if (wr_tma) tma <= bus.din;
      if (wr_tac) tac <= bus.din[TAC_W-1:0];
    end
  end

  always_comb begin
    bus.dout = 8'hFF;
    if (bus.hit) begin
      case (ofs)
        OFS_DIV:  bus.dout = div;
        OFS_TIMA: bus.dout = tima;
        OFS_TMA:  bus.dout = tma;
        default:  bus.dout = {5'b11111, tac};
      endcase
    end
  end

`ifdef GB_TIMER_OVF_DELAY_EN
  logic [1:0]            state, state_n;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tima <= '0;
      irq  <= 1'b0;
    end else begin
      tima <= tima_n;
      irq  <= irq_n;
    end
  end

  // Overflow handling: TIMA next value and interrupt request
  always_comb begin
    tima_n = tima;
    irq_n  = 1'b0;
`ifdef GB_TIMER_OVF_DELAY_EN
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      ST_WAIT: begin
        if (wr_tima) begin
          tima_n  = bus.din;
          state_n = ST_IDLE;
        end else if (wait_cnt == WAIT_CNT_W'(WAIT_LEN - 1)) begin
          tima_n  = tma;
          irq_n   = 1'b1;
          state_n = ST_RELOAD;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_CNT_W'(1);
          if (tick) tima_n = tima + DATA_W'(1);
        end
      end
      ST_RELOAD: begin
        // TIMA already holds TMA; only a TMA write can change it here
        state_n = ST_IDLE;
        if (wr_tma) tima_n = bus.din;
      end
      default: begin
        if (wr_tima) begin
          tima_n = bus.din;
        end else if (tick) begin
          if (tima == 8'hFF) begin
            tima_n     = '0;
            wait_cnt_n = '0;
            state_n    = ST_WAIT;
          end else begin
            tima_n = tima + DATA_W'(1);
          end
        end
      end
    endcase
`else
    if (wr_tima) begin
      tima_n = bus.din;
    end else if (tick) begin
      if (tima == 8'hFF) begin
        tima_n = tma;
        irq_n  = 1'b1;
      end else begin
        tima_n = tima + DATA_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: cycle-level reference model compared every cycle, plus
// directed scenarios with hand-computed register values.
module tb_gb_timer;
  import gb_timer_pkg::*;

  localparam logic [15:0] BASE = 16'hFF04;
  localparam int SEL [4] = '{9, 3, 5, 7};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  gb_timer_if bus_if ();

  gb_timer #(.BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_rng(input logic [15:0] addr);
    logic [15:0] d;
    d = addr - BASE;
    return d < 16'd4;
  endfunction

  // Reference model: register contents as the rules define them
  logic [15:0] m_div;
  logic        m_prev;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  logic        m_irq;
  int          m_pend, m_rwin, m_n;

  function automatic logic [7:0] m_reg(input logic [1:0] o);
    case (o)
      2'd0:    return m_div[15:8];
      2'd1:    return m_tima;
      2'd2:    return m_tma;
      default: return {5'b11111, m_tac};
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic src, tick, irq_n, w;
    logic [1:0] o;
    logic [7:0] t_n;
    if (!rst) begin
      m_div = '0; m_prev = 1'b0; m_tima = '0; m_tma = '0; m_tac = '0;
      m_irq = 1'b0; m_pend = -1; m_rwin = -1; m_n = 0;
    end else begin
      src   = m_tac[2] & m_div[SEL[m_tac[1:0]]];
      tick  = m_prev & ~src;
      w     = bus_if.wr && in_rng(bus_if.a);
      o     = 2'(bus_if.a - BASE);
      irq_n = 1'b0;
      t_n   = m_tima;
      if (m_pend == m_n) begin
        if (w && o == 2'd1) t_n = bus_if.din;
        else begin
          t_n = m_tma; irq_n = 1'b1; m_rwin = m_n + 1;
        end
        m_pend = -1;
      end else if (m_pend > m_n) begin
        if (w && o == 2'd1) begin
          t_n = bus_if.din; m_pend = -1;
        end else if (tick) t_n = m_tima + 8'd1;
      end else if (m_rwin == m_n) begin
        if (w && o == 2'd2) t_n = bus_if.din;
      end else if (w && o == 2'd1) begin
        t_n = bus_if.din;
      end else if (tick) begin
        if (m_tima == 8'hFF) begin
`ifdef GB_TIMER_OVF_DELAY_EN
          t_n = 8'h00; m_pend = m_n + 4;
`else
          t_n = m_tma; irq_n = 1'b1;
`endif
        end else t_n = m_tima + 8'd1;
      end
      m_tima = t_n;
      if (w && o == 2'd2) m_tma = bus_if.din;
      if (w && o == 2'd3) m_tac = bus_if.din[2:0];
      m_div  = (w && o == 2'd0) ? 16'h0000 : m_div + 16'd1;
      m_prev = src;
      m_irq  = irq_n;
      m_n++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : compare
    logic e_hit;
    e_hit = bus_if.rd && in_rng(bus_if.a);
    chk("hit", 8'(bus_if.hit), 8'(e_hit));
    chk("dout", bus_if.dout, e_hit ? m_reg(2'(bus_if.a - BASE)) : 8'hFF);
    chk("irq", 8'(irq), 8'(m_irq));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [7:0] v);
    bus_if.a = BASE + 16'(off);
    #1;
    v = bus_if.dout;
    bus_if.a = BASE + 16'd1;
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] d);
    bus_if.a   = BASE + 16'(off);
    bus_if.din = d;
    bus_if.wr  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.wr  = 1'b0;
    bus_if.a   = BASE + 16'd1;
  endtask

  task automatic wait_ovf(output logic ok);
    logic [7:0] v;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      rd_reg(2'd1, v);
      if (v != 8'hFF) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("ovf_wait_timeout", 8'(ok), 8'h01);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] v, t0;
    logic ok;
`ifdef GB_TIMER_OVF_DELAY_EN
    localparam logic [7:0] RELOAD_VAL = 8'hAB;
`else
    localparam logic [7:0] RELOAD_VAL = 8'h10;
`endif
    bus_if.a = BASE + 16'd1; bus_if.din = '0; bus_if.rd = 1'b1; bus_if.wr = 1'b0;

    // Reset state
    cyc(3);
    rd_reg(2'd1, v); chk("rst_tima", v, 8'h00);
    rd_reg(2'd3, v); chk("rst_tac", v, 8'hF8);
    chk("rst_irq", 8'(irq), 8'h00);
    rst = 1'b1;
    cyc(1);

    // Counting from a known divider phase with TAC=101
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd0, 8'h00);
    wr_reg(2'd1, 8'h00);
    wr_reg(2'd3, 8'h05);
    cyc(14); rd_reg(2'd1, v); chk("tima_pre16", v, 8'h00);
    cyc(1);  rd_reg(2'd1, v); chk("tima_16", v, 8'h01);
    cyc(16); rd_reg(2'd1, v); chk("tima_32", v, 8'h02);
    cyc(222); rd_reg(2'd0, v); chk("div_255", v, 8'h00);
    cyc(1);  rd_reg(2'd0, v); chk("div_256", v, 8'h01);

    // Overflow and reload
    wr_reg(2'd2, RELOAD_VAL);
    wr_reg(2'd1, 8'hFF);
    wait_ovf(ok);
`ifdef GB_TIMER_OVF_DELAY_EN
    rd_reg(2'd1, v); chk("wait0_tima", v, 8'h00);
    chk("wait0_irq", 8'(irq), 8'h00);
    for (int k = 1; k < 4; k++) begin
      cyc(1);
      rd_reg(2'd1, v); chk("wait_tima", v, 8'h00);
      chk("wait_irq", 8'(irq), 8'h00);
    end
    cyc(1);
    rd_reg(2'd1, v); chk("reload_tima", v, 8'hAB);
    chk("reload_irq", 8'(irq), 8'h01);
`else
    rd_reg(2'd1, v); chk("ovf_tima", v, 8'h10);
    chk("ovf_irq", 8'(irq), 8'h01);
`endif
    cyc(1);
    chk("irq_drop", 8'(irq), 8'h00);
    rd_reg(2'd1, v); chk("after_tima", v, RELOAD_VAL);

    // TIMA write in the second WAIT cycle cancels the reload
    wr_reg(2'd1, 8'hFF);
    wait_ovf(ok);
    cyc(1);
    wr_reg(2'd1, 8'h42);
    rd_reg(2'd1, v); chk("cancel_tima", v, 8'h42);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("cancel_irq", 8'(irq), 8'h00);
    end

    // DIV write while the selected bit is high produces one tick
    wr_reg(2'd1, 8'h10);
    wr_reg(2'd3, 8'h04);
    cyc(2);
    ok = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      rd_reg(2'd0, v);
      if (v[1:0] == 2'b10) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("bit9_wait_timeout", 8'(ok), 8'h01);
    rd_reg(2'd1, t0);
    wr_reg(2'd0, 8'h5A);
    rd_reg(2'd0, v); chk("divclr_div", v, 8'h00);
    rd_reg(2'd1, v); chk("divclr_tima0", v, t0);
    cyc(1);
    rd_reg(2'd1, v); chk("divclr_tima1", v, t0 + 8'd1);

    // Read decode
    wr_reg(2'd3, 8'h07);
    rd_reg(2'd3, v); chk("tac_read", v, 8'hFF);
    cyc(1);
    bus_if.a = 16'hFF08; #1;
    chk("ff08_hit", 8'(bus_if.hit), 8'h00);
    chk("ff08_dout", bus_if.dout, 8'hFF);
    cyc(1);
    bus_if.a = 16'hFF03; #1;
    chk("ff03_hit", 8'(bus_if.hit), 8'h00);
    bus_if.a = BASE + 16'd1; bus_if.rd = 1'b0; #1;
    chk("nord_hit", 8'(bus_if.hit), 8'h00);
    chk("nord_dout", bus_if.dout, 8'hFF);
    bus_if.rd = 1'b1;
    cyc(1);

    // Reset during the pending reload: no interrupt afterwards
    wr_reg(2'd3, 8'h05);
    wr_reg(2'd1, 8'hFF);
    wait_ovf(ok);
    cyc(1);
    rst = 1'b0;
    #1;
    chk("rstmid_irq", 8'(irq), 8'h00);
    rd_reg(2'd1, v); chk("rstmid_tima", v, 8'h00);
    cyc(2);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk("rstmid_no_irq", 8'(irq), 8'h00);
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_timer.md
Name: gb_timer

Overview:
- Bus-responder peripheral on the SoC internal bus; answers CPU reads and writes at 0xFF04–0xFF07.
- Registers: DIV, TIMA, TMA, TAC.
- Counts from the 4.19 MHz system clock and raises a one-cycle timer interrupt request on TIMA overflow.
- Sits beside the CPU; its read data is muxed into the CPU data-in path.

Parameters:
- BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC follow at +1/+2/+3.

Ports:
- clk  input  1  4.19 MHz system clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- a  input  16  bus address from master.
- din  input  8  write data, master to slave.
- dout  output  8  read data, slave to master.
- rd  input  1  read enable, level.
- wr  input  1  write strobe; one clk per write access.
- hit  output  1  combinational; 1 when a is in BASE_ADDR..BASE_ADDR+3 and rd=1. Used by the bus mux.
- irq  output  1  timer interrupt request; one-clk pulse.

Behaviour:
- Reset (rst=0, async): div_cnt=16'h0000, TIMA=0, TMA=0, TAC=3'b000, ovf state IDLE, irq=0. dout reads 8'hFF while a hit is not active.

Divider:
- 16-bit div_cnt increments every clk and wraps 0xFFFF→0x0000.
- DIV = div_cnt[15:8].
- Any write to DIV clears div_cnt to 0 on that edge; written data is ignored.

Tick generation:
- sel_bit = div_cnt[9 | 3 | 5 | 7] for TAC[1:0] = 00 | 01 | 10 | 11.
- tick_src = TAC[2] & sel_bit.
- TIMA increments on each 1→0 transition of tick_src, registered as previous vs current.
- A falling edge caused by a DIV write or a TAC write also increments TIMA (glitch-compatible).

Overflow:
- TIMA=0xFF plus a tick → TIMA=0x00 and the FSM leaves IDLE.
- With OVF_DELAY (see Optional Feature): state WAIT for 4 clk, TIMA reads 0x00, then RELOAD for 1 clk. In RELOAD: TIMA←TMA and irq=1.
- Write to TIMA during WAIT: write wins, reload and irq are cancelled, FSM returns to IDLE.
- Write to TIMA during RELOAD: ignored; TMA value wins.
- Write to TMA during RELOAD: the new TMA value is loaded into TIMA the same edge.
- Tick arriving during WAIT: increments TIMA from 0x00.

Reads:
- Combinational; dout valid the same cycle as rd.
- DIV → div_cnt[15:8]; TIMA → TIMA; TMA → TMA; TAC → {5'b11111, TAC}.
- Non-hit → 8'hFF.

Writes:
- Take effect on the rising clk edge with wr=1 and a in range.
- TAC takes only din[2:0].
- Simultaneous tick and TIMA write: write wins.

Other rules:
- irq is registered, high for exactly 1 clk per overflow, and never asserts during reset.
- rst asserted mid-WAIT aborts the pending reload; no irq is produced.

Optional Feature:
- Macro GB_TIMER_OVF_DELAY_EN.
- Defined: 4-clk WAIT with TIMA=0x00, then RELOAD + irq, as above.
- Undefined: on overflow TIMA←TMA and irq=1 on the same edge as the overflowing tick; WAIT and RELOAD states are absent, and the cancel/override rules do not apply.

Decomposition:
- Shared package gb_timer_pkg holds:
  - register offsets: OFS_DIV=0, OFS_TIMA=1, OFS_TMA=2, OFS_TAC=3;
  - TAC clock-select bit indices (9, 3, 5, 7);
  - ovf FSM state encoding (IDLE, WAIT, RELOAD);
  - WAIT length constant 4.
- One sub-module, gb_timer_prescaler: div_cnt, clear-on-write, sel_bit mux and falling-edge detect; outputs div[7:0] and tick.

Test Plan:
- Reset release, TAC=3'b101, TIMA=0: TIMA=1 after 16 clk, 2 after 32 clk; DIV=0x01 after 256 clk.
- TAC=3'b101, TMA=0xAB, TIMA=0xFF, tick occurs (delay enabled): TIMA reads 0x00 for 4 clk, then 0xAB, with irq high exactly 1 clk on the reload edge.
- Same setup with a write TIMA=0x42 during the 2nd WAIT clk: TIMA=0x42 and no irq pulse.
- TAC=3'b100, div_cnt bit9=1, write DIV: TIMA increments by 1 immediately and DIV reads 0x00.
- Read TAC after writing 0x07: returns 0xFF; read 0xFF08 with rd=1: hit=0, dout=0xFF.
- Macro undefined, TIMA=0xFF, TMA=0x10, tick: TIMA=0x10 and irq=1 on the same edge.
